// File: rtl/tile_board_render_pkg.sv
// Shared definitions for the tile-board renderer.
// Holds the default board geometry, the default key and cursor colours, the
// 12-bit RGB and counter widths, a packed bundle for the VGA timing signals,
// and a helper that tests whether a counter lies inside a power-of-two span.
package tile_board_render_pkg;

    localparam int RGB_W = 12;
    localparam int CNT_W = 12;

    localparam int H_MIN_DEF     = 448;
    localparam int V_MIN_DEF     = 28;
    localparam int TILE_LOG2_DEF = 6;
    localparam int COL_BITS_DEF  = 4;
    localparam int ROW_BITS_DEF  = 4;
    localparam int CODE_W_DEF    = 4;

    localparam logic [RGB_W-1:0] KEY_RGB_DEF = 12'hF0F;
    localparam logic [RGB_W-1:0] CUR_RGB_DEF = 12'hFF0;

    typedef logic [RGB_W-1:0] rgb_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // hcount + hsync + hblnk + vcount + vsync + vblnk = 28 bits
    typedef struct packed {
        cnt_t hcount;
        logic hsync;
        logic hblnk;
        cnt_t vcount;
        logic vsync;
        logic vblnk;
    } timing_t;

    localparam int TIMING_W = $bits(timing_t);

    // lo <= c < lo + 2^span_log2. Subtracting first lets counters below lo
    // wrap to large values, so a single unsigned compare covers both bounds.
    function automatic logic in_span(input cnt_t c, input cnt_t lo, input int span_log2);
        cnt_t d;
        d = c - lo;
        return 32'(d) < (32'd1 << span_log2);
    endfunction

endpackage

// File: rtl/tile_board_render_if.sv
// Tile lookup bus between the renderer and the tile-map / tile-ROM memories.
//  map_addr   {row, col} into the tile map
//  map_code   tile code returned by the map, one cycle after map_addr
//  tile_code  tile code forwarded to the ROM bank select
//  rom_addr   {y_in_tile, x_in_tile} into the tile ROM
//  rom_rgb    ROM pixel, a fixed number of cycles after rom_addr
// The renderer uses the master modport, the memory side the slave modport.
interface tile_board_render_if
    import tile_board_render_pkg::*;
#(
    parameter int ROW_BITS  = ROW_BITS_DEF,
    parameter int COL_BITS  = COL_BITS_DEF,
    parameter int CODE_W    = CODE_W_DEF,
    parameter int TILE_LOG2 = TILE_LOG2_DEF
);
    logic [ROW_BITS+COL_BITS-1:0] map_addr;
    logic [CODE_W-1:0]            map_code;
    logic [CODE_W-1:0]            tile_code;
    logic [2*TILE_LOG2-1:0]       rom_addr;
    rgb_t                         rom_rgb;

    modport master (
        output map_addr, tile_code, rom_addr,
        input  map_code, rom_rgb
    );

    modport slave (
        input  map_addr, tile_code, rom_addr,
        output map_code, rom_rgb
    );
endinterface

// File: rtl/tile_board_render_delay.sv
// Fixed-length delay line with synchronous clear.
//  i_pclk   clock
//  i_rst    synchronous reset, active-high; clears every stage
//  i_din    WIDTH-bit input word
//  o_dout   i_din delayed by CLK_DEL cycles (CLK_DEL >= 1)
module tile_board_render_delay #(
    parameter int WIDTH   = 8,
    parameter int CLK_DEL = 1
) (
    input  logic             i_pclk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);
    logic [WIDTH-1:0] sr_q [CLK_DEL];
    logic [WIDTH-1:0] sr_d [CLK_DEL];

    always_comb begin
        sr_d[0] = i_din;
        for (int i = 1; i < CLK_DEL; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            for (int i = 0; i < CLK_DEL; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            sr_q <= sr_d;
        end
    end

    assign o_dout = sr_q[CLK_DEL-1];
endmodule

// File: rtl/tile_board_render.sv
// Tile-map board renderer in the VGA timing chain.
// Maps (hcount, vcount) onto a grid of 2^COL_BITS x 2^ROW_BITS tiles of
// 2^TILE_LOG2 pixels, drives the tile-map and tile-ROM addresses over the
// lookup bus, delays timing and upstream RGB to meet the ROM data, then
// registers the final pixel. Adds colour-key transparency and a blinking
// cursor frame whose position is latched once per frame.
// Ports:
//  i_pclk, i_rst                 pixel clock, synchronous active-high reset
//  i_hcount..i_vblnk, i_rgb      upstream timing and pixel
//  lut                           lookup bus (map/ROM addresses and data)
//  i_cur_x, i_cur_y, i_cur_en    requested cursor tile and enable
//  o_hcount..o_vblnk, o_rgb      timing and pixel, ROM_LAT+1 cycles later
module tile_board_render
    import tile_board_render_pkg::*;
#(
    parameter int         H_MIN      = H_MIN_DEF,
    parameter int         V_MIN      = V_MIN_DEF,
    parameter int         TILE_LOG2  = TILE_LOG2_DEF,
    parameter int         COL_BITS   = COL_BITS_DEF,
    parameter int         ROW_BITS   = ROW_BITS_DEF,
    parameter int         CODE_W     = CODE_W_DEF,
    parameter int         ROM_LAT    = 2,
    parameter logic [11:0] KEY_RGB   = KEY_RGB_DEF,
    parameter logic [11:0] CUR_RGB   = CUR_RGB_DEF,
    parameter int         CUR_THICK  = 2,
    parameter int         BLINK_LOG2 = 5
) (
    input  logic                i_pclk,
    input  logic                i_rst,
    input  logic [11:0]         i_hcount,
    input  logic                i_hsync,
    input  logic                i_hblnk,
    input  logic [11:0]         i_vcount,
    input  logic                i_vsync,
    input  logic                i_vblnk,
    input  logic [11:0]         i_rgb,
    tile_board_render_if.master lut,
    input  logic [COL_BITS-1:0] i_cur_x,
    input  logic [ROW_BITS-1:0] i_cur_y,
    input  logic                i_cur_en,
    output logic [11:0]         o_hcount,
    output logic                o_hsync,
    output logic                o_hblnk,
    output logic [11:0]         o_vcount,
    output logic                o_vsync,
    output logic                o_vblnk,
    output logic [11:0]         o_rgb
);
    localparam int DEL_W = TIMING_W + RGB_W + 2*TILE_LOG2;
    localparam logic [TILE_LOG2-1:0] EDGE_LO = TILE_LOG2'(CUR_THICK);
    localparam logic [TILE_LOG2-1:0] EDGE_HI = TILE_LOG2'((1 << TILE_LOG2) - CUR_THICK);

    function automatic logic on_edge(input logic [TILE_LOG2-1:0] p);
        return (p < EDGE_LO) || (p >= EDGE_HI);
    endfunction

    timing_t              tin, tdel;
    cnt_t                 dx, dy, dhx, dvy;
    rgb_t                 rgb_del;
    logic [TILE_LOG2-1:0] lx_del, ly_del;
    logic [DEL_W-1:0]     del_out;

    // Input side: board-relative coordinates and lookup addresses
    assign tin = '{hcount: i_hcount, hsync: i_hsync, hblnk: i_hblnk,
                   vcount: i_vcount, vsync: i_vsync, vblnk: i_vblnk};
    assign dx  = i_hcount - cnt_t'(H_MIN);
    assign dy  = i_vcount - cnt_t'(V_MIN);

    assign lut.map_addr  = {dy[TILE_LOG2+:ROW_BITS], dx[TILE_LOG2+:COL_BITS]};
    assign lut.rom_addr  = {dy[TILE_LOG2-1:0], dx[TILE_LOG2-1:0]};
    assign lut.tile_code = CODE_W'(lut.map_code);

    // Delay stage: align timing, upstream pixel and in-tile x/y with ROM data
    tile_board_render_delay #(
        .WIDTH   (DEL_W),
        .CLK_DEL (ROM_LAT)
    ) u_delay (
        .i_pclk (i_pclk),
        .i_rst  (i_rst),
        .i_din  ({tin, i_rgb, dy[TILE_LOG2-1:0], dx[TILE_LOG2-1:0]}),
        .o_dout (del_out)
    );

    assign {tdel, rgb_del, ly_del, lx_del} = del_out;

    // Tile column/row of the delayed pixel, for the cursor compare
    assign dhx = tdel.hcount - cnt_t'(H_MIN);
    assign dvy = tdel.vcount - cnt_t'(V_MIN);

    logic unused_bits;
    assign unused_bits = ^{dx[CNT_W-1:TILE_LOG2+COL_BITS], dy[CNT_W-1:TILE_LOG2+ROW_BITS],
                           dhx[TILE_LOG2-1:0], dhx[CNT_W-1:TILE_LOG2+COL_BITS],
                           dvy[TILE_LOG2-1:0], dvy[CNT_W-1:TILE_LOG2+ROW_BITS]};

    // Frame counter and cursor shadow, both advanced on the vblnk rising edge
    logic                  vblnk_prev_q, vblnk_prev_d;
    logic [BLINK_LOG2-1:0] frame_q, frame_d;
    logic [COL_BITS-1:0]   cur_x_q, cur_x_d;
    logic [ROW_BITS-1:0]   cur_y_q, cur_y_d;
    logic                  cur_en_q, cur_en_d;
    timing_t               tout_q, tout_d;
    rgb_t                  rgb_q, rgb_d;

    logic vblnk_rise, in_board, cur_tile, show_cur;

    assign vblnk_rise = i_vblnk & ~vblnk_prev_q;
    assign in_board   = in_span(tdel.hcount, cnt_t'(H_MIN), COL_BITS + TILE_LOG2) &&
                        in_span(tdel.vcount, cnt_t'(V_MIN), ROW_BITS + TILE_LOG2);
    assign cur_tile   = (dhx[TILE_LOG2+:COL_BITS] == cur_x_q) &&
                        (dvy[TILE_LOG2+:ROW_BITS] == cur_y_q);
    assign show_cur   = cur_tile && cur_en_q && frame_q[BLINK_LOG2-1] &&
                        (on_edge(lx_del) || on_edge(ly_del));

    always_comb begin
        vblnk_prev_d = i_vblnk;
        frame_d      = frame_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        cur_en_d     = cur_en_q;
        if (vblnk_rise) begin
            frame_d  = frame_q + BLINK_LOG2'(1);
            cur_x_d  = i_cur_x;
            cur_y_d  = i_cur_y;
            cur_en_d = i_cur_en;
        end

        tout_d = tdel;
        if (tdel.vblnk || tdel.hblnk) begin
            rgb_d = '0;
        end else if (!in_board) begin
            rgb_d = rgb_del;
        end else if (show_cur) begin
            rgb_d = CUR_RGB;
        end else if (lut.rom_rgb == KEY_RGB) begin
            rgb_d = rgb_del;
        end else begin
            rgb_d = lut.rom_rgb;
        end
    end

    // Output stage
    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            vblnk_prev_q <= 1'b0;
            frame_q      <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            cur_en_q     <= 1'b0;
            tout_q       <= '0;
            rgb_q        <= '0;
        end else begin
            vblnk_prev_q <= vblnk_prev_d;
            frame_q      <= frame_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            cur_en_q     <= cur_en_d;
            tout_q       <= tout_d;
            rgb_q        <= rgb_d;
        end
    end

    assign o_hcount = tout_q.hcount;
    assign o_hsync  = tout_q.hsync;
    assign o_hblnk  = tout_q.hblnk;
    assign o_vcount = tout_q.vcount;
    assign o_vsync  = tout_q.vsync;
    assign o_vblnk  = tout_q.vblnk;
    assign o_rgb    = rgb_q;
endmodule

// File: tb/tb_tile_board_render.sv
// Self-checking bench for tile_board_render. Each driven pixel pushes its
// expected output onto a queue with the cycle it is due; outputs are popped
// and compared on the falling clock edge.
module tb_tile_board_render;
    import tile_board_render_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] i_hcount, i_vcount, i_rgb;
    logic        i_hsync, i_hblnk, i_vsync, i_vblnk;
    logic [3:0]  i_cur_x, i_cur_y;
    logic        i_cur_en;
    logic [11:0] o_hcount, o_vcount, o_rgb;
    logic        o_hsync, o_hblnk, o_vsync, o_vblnk;

    tile_board_render_if lut ();

    tile_board_render dut (
        .i_pclk   (clk),
        .i_rst    (rst),
        .i_hcount (i_hcount),
        .i_hsync  (i_hsync),
        .i_hblnk  (i_hblnk),
        .i_vcount (i_vcount),
        .i_vsync  (i_vsync),
        .i_vblnk  (i_vblnk),
        .i_rgb    (i_rgb),
        .lut      (lut),
        .i_cur_x  (i_cur_x),
        .i_cur_y  (i_cur_y),
        .i_cur_en (i_cur_en),
        .o_hcount (o_hcount),
        .o_hsync  (o_hsync),
        .o_hblnk  (o_hblnk),
        .o_vcount (o_vcount),
        .o_vsync  (o_vsync),
        .o_vblnk  (o_vblnk),
        .o_rgb    (o_rgb)
    );

    always #5 clk = ~clk;

    // Memory model: tile code one cycle after map_addr, ROM pixel two cycles
    // after the address (rom_src is the colour stored for the driven pixel).
    logic [11:0] rom_src = '0, rom_p0 = '0, rom_p1 = '0;
    logic [3:0]  map_code_r = '0;
    always @(posedge clk) begin
        rom_p0     <= rom_src;
        rom_p1     <= rom_p0;
        map_code_r <= lut.map_addr[3:0] ^ 4'h5;
    end
    assign lut.rom_rgb  = rom_p1;
    assign lut.map_code = map_code_r;

    typedef struct {
        string       tag;
        int          due;
        logic [11:0] h, v, rgb;
        logic [3:0]  flags;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference state: frame count and latched cursor
    int   frame_m = 0;
    int   sh_x = 0, sh_y = 0;
    bit   sh_en = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [11:0] model_rgb(input int h, v, input logic hb, vb,
                                              input logic [11:0] rgb, rom);
        int dx, dy, col, row, lx, ly;
        bit frame_px;
        if (hb || vb) return 12'h000;
        dx = h - 448;
        dy = v - 28;
        if (dx < 0 || dx >= 1024 || dy < 0 || dy >= 1024) return rgb;
        col = dx / 64;  lx = dx % 64;
        row = dy / 64;  ly = dy % 64;
        frame_px = (lx < 2) || (lx >= 62) || (ly < 2) || (ly >= 62);
        if (sh_en && frame_m >= 16 && col == sh_x && row == sh_y && frame_px) return 12'hFF0;
        if (rom == 12'hF0F) return rgb;
        return rom;
    endfunction

    task automatic score();
        exp_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            check_eq({e.tag, ".due"}, cyc, e.due);
            check_eq({e.tag, ".hcount"}, o_hcount, e.h);
            check_eq({e.tag, ".vcount"}, o_vcount, e.v);
            check_eq({e.tag, ".sync"}, {o_hsync, o_hblnk, o_vsync, o_vblnk}, e.flags);
            check_eq({e.tag, ".rgb"}, o_rgb, e.rgb);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        score();
    endtask

    task automatic px(input string tag, input int h, v, input logic hs, hb, vs, vb,
                      input logic [11:0] rgb, rom);
        exp_t e;
        tick();
        i_hcount = 12'(h);  i_vcount = 12'(v);
        i_hsync  = hs;      i_hblnk  = hb;
        i_vsync  = vs;      i_vblnk  = vb;
        i_rgb    = rgb;     rom_src  = rom;
        e.tag   = tag;
        e.due   = cyc + 3;
        e.h     = 12'(h);
        e.v     = 12'(v);
        e.flags = {hs, hb, vs, vb};
        e.rgb   = model_rgb(h, v, hb, vb, rgb, rom);
        sbq.push_back(e);
    endtask

    task automatic pxb(input string tag, input int h, v, input logic [11:0] rgb, rom);
        px(tag, h, v, 1'b0, 1'b0, 1'b0, 1'b0, rgb, rom);
    endtask

    // Blank padding keeps earlier pixels clear of the counter update; the two
    // vblnk pixels sit on the board and must come out black.
    task automatic vblank();
        px("pad", 500, 100, 1'b1, 1'b1, 1'b0, 1'b0, 12'h321, 12'h654);
        px("pad", 500, 100, 1'b0, 1'b1, 1'b0, 1'b0, 12'h321, 12'h654);
        px("vb", 640, 163, 1'b0, 1'b0, 1'b1, 1'b1, 12'h123, 12'hFF0);
        px("vb", 641, 164, 1'b0, 1'b0, 1'b1, 1'b1, 12'h123, 12'h456);
        frame_m = (frame_m + 1) % 32;
        sh_x    = int'(i_cur_x);
        sh_y    = int'(i_cur_y);
        sh_en   = i_cur_en;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, ".hcount"}, o_hcount, 0);
        check_eq({tag, ".vcount"}, o_vcount, 0);
        check_eq({tag, ".sync"}, {o_hsync, o_hblnk, o_vsync, o_vblnk}, 0);
        check_eq({tag, ".rgb"}, o_rgb, 0);
    endtask

    task automatic mid_reset();
        tick();
        rst = 1'b1;
        @(negedge clk);
        cyc++;
        check_zero("t6_rst");
        rst = 1'b0;
        sbq.delete();
        frame_m = 0;
        sh_en   = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_hcount = '0; i_vcount = '0; i_rgb = '0;
        i_hsync = 0; i_hblnk = 0; i_vsync = 0; i_vblnk = 0;
        i_cur_x = 4'd3; i_cur_y = 4'd2; i_cur_en = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Addresses and tile code pass-through
        pxb("t1", 645, 163, 12'h111, 12'h222);
        #1;
        check_eq("t1.map_addr", lut.map_addr, 8'h23);
        check_eq("t1.rom_addr", lut.rom_addr, 12'h1C5);
        pxb("t1b", 100, 100, 12'h0AB, 12'h0CD);
        #1;
        check_eq("t1.tile_code", lut.tile_code, 4'h6);

        // Latency: one board pixel among outside pixels
        pxb("t2", 448, 28, 12'hABC, 12'h0F0);
        pxb("t2b", 200, 28, 12'h777, 12'h0F0);

        // Transparency, pass-through, blanking, board edges
        pxb("t3key", 500, 100, 12'h123, 12'hF0F);
        px("t3out", 100, 100, 1'b1, 1'b0, 1'b1, 1'b0, 12'h456, 12'h789);
        px("t3hb", 500, 100, 1'b0, 1'b1, 1'b0, 1'b0, 12'h456, 12'h789);
        pxb("t3h_in", 1471, 100, 12'h111, 12'h345);
        pxb("t3h_out", 1472, 100, 12'h222, 12'h345);
        pxb("t3h_lo", 447, 100, 12'h333, 12'h345);
        pxb("t3v_in", 500, 1051, 12'h444, 12'h346);
        pxb("t3v_out", 500, 1052, 12'h555, 12'h346);
        vblank();

        // Cursor blink over many frames; mid-frame cursor move at frame 20
        for (int f = 2; f <= 40; f++) begin
            vblank();
            pxb("t4edge", 640, 163, 12'h0AA, 12'h5A5);
            pxb("t4int", 660, 163, 12'h0AA, 12'h5A5);
            pxb("t5new", 768, 163, 12'h0BB, 12'h5A6);
            if (f == 20) begin
                i_cur_x = 4'd5;
                pxb("t5old", 640, 164, 12'h0AA, 12'h5A5);
                pxb("t5hold", 768, 164, 12'h0BB, 12'h5A6);
            end
        end

        // Reset mid-frame, then counter restarts from zero
        pxb("t6pre", 768, 163, 12'h0BB, 12'h5A6);
        pxb("t6pre", 769, 163, 12'h0BB, 12'h5A6);
        mid_reset();
        pxb("t6hide", 768, 163, 12'h0BB, 12'h5A6);
        for (int f = 1; f <= 17; f++) begin
            vblank();
            pxb("t6blink", 768, 163, 12'h0BB, 12'h5A6);
        end

        for (int i = 0; i < 6 && sbq.size() > 0; i++) tick();
        check_eq("drain", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
